// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive controller: state encoding,
// check-point offset and the legal oversampling ratios.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PARITY  = 3'd3,
        ST_STOP    = 3'd4,
        ST_ERR_CHK = 3'd5
    } rx_state_e;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    // Check point sits this many edges past P/2: one cycle after the
    // sampler's three mid-bit samples.
    localparam logic [5:0] CP_OFFSET = 6'd2;

    localparam logic [3:0] LAST_DATA_BIT = 4'd8;

    // Unsupported ratios fall back to x8 oversampling.
    function automatic logic [5:0] legal_prescale(input logic [5:0] p);
        logic [5:0] r;
        case (p)
            PRESCALE_8, PRESCALE_16, PRESCALE_32: r = p;
            default:                              r = PRESCALE_8;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/edge_bit_counter.sv
// Oversample edge counter with bit counter: counts edges within a bit,
// wraps at last_edge_i and advances the bit index. Clear and preload
// take priority over counting.
module edge_bit_counter #(
    parameter int unsigned EDGE_W = 6,
    parameter int unsigned BIT_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              clear_i,
    input  logic              preload_i,
    input  logic [EDGE_W-1:0] last_edge_i,
    output logic [EDGE_W-1:0] edge_cnt_o,
    output logic [BIT_W-1:0]  bit_cnt_o
);

    logic [EDGE_W-1:0] edge_q, edge_d;
    logic [BIT_W-1:0]  bit_q, bit_d;

    // Next counter values: clear, preload-to-1, or count with wrap.
    always_comb begin
        edge_d = edge_q;
        bit_d  = bit_q;
        if (clear_i) begin
            edge_d = '0;
            bit_d  = '0;
        end else if (preload_i) begin
            edge_d = EDGE_W'(1);
            bit_d  = '0;
        end else if (en_i) begin
            if (edge_q == last_edge_i) begin
                edge_d = '0;
                bit_d  = bit_q + BIT_W'(1);
            end else begin
                edge_d = edge_q + EDGE_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            edge_q <= '0;
            bit_q  <= '0;
        end else begin
            edge_q <= edge_d;
            bit_q  <= bit_d;
        end
    end

    assign edge_cnt_o = edge_q;
    assign bit_cnt_o  = bit_q;

endmodule

// File: rtl/rx_fsm.sv
// UART receive controller: sequences start/data/parity/stop bits at the
// oversampled clock and issues sampler/checker enables and data_valid.
module rx_fsm
    import uart_rx_pkg::*;
(
    input  logic       clk_fsm,
    input  logic       rst_fsm,
    input  logic       rx_in_fsm,
    input  logic [5:0] prescale_fsm,
    input  logic       par_en_fsm,
    input  logic       strt_glitch_fsm,
    input  logic       par_error_fsm,
    input  logic       stop_error_fsm,
    output logic [5:0] edge_cnt_fsm,
    output logic [3:0] bit_cnt_fsm,
    output logic       dat_samp_en_fsm,
    output logic       strt_chk_en_fsm,
    output logic       deser_en_fsm,
    output logic       par_chk_en_fsm,
    output logic       stop_chk_en_fsm,
    output logic       data_valid_fsm,
    output logic       busy_fsm
);

    rx_state_e  state_q, state_d;
    logic [5:0] prescale_q, prescale_d;
    logic       par_en_q, par_en_d;

    logic       cnt_en, cnt_clear, cnt_preload;
    logic [5:0] last_edge;
    logic [5:0] chk_point;
    logic       at_last;
    logic       at_cp;

    assign last_edge = prescale_q - 6'd1;
    assign chk_point = (prescale_q >> 1) + CP_OFFSET;
    assign at_last   = (edge_cnt_fsm == last_edge);
    assign at_cp     = (edge_cnt_fsm == chk_point);

    edge_bit_counter #(
        .EDGE_W (6),
        .BIT_W  (4)
    ) u_cnt (
        .clk_i       (clk_fsm),
        .rst_ni      (rst_fsm),
        .en_i        (cnt_en),
        .clear_i     (cnt_clear),
        .preload_i   (cnt_preload),
        .last_edge_i (last_edge),
        .edge_cnt_o  (edge_cnt_fsm),
        .bit_cnt_o   (bit_cnt_fsm)
    );

    // State register plus frame configuration captured at frame start.
    always_ff @(posedge clk_fsm or negedge rst_fsm) begin
        if (!rst_fsm) begin
            state_q    <= ST_IDLE;
            prescale_q <= PRESCALE_8;
            par_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            prescale_q <= prescale_d;
            par_en_q   <= par_en_d;
        end
    end

    // Next-state, counter control and configuration capture.
    always_comb begin
        state_d    = state_q;
        prescale_d = prescale_q;
        par_en_d   = par_en_q;
        case (state_q)
            ST_IDLE:    if (!rx_in_fsm) state_d = ST_START;
            ST_START:   if (at_last) state_d = strt_glitch_fsm ? ST_IDLE : ST_DATA;
            ST_DATA:    if (at_last && (bit_cnt_fsm == LAST_DATA_BIT))
                            state_d = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY:  if (at_last) state_d = ST_STOP;
            ST_STOP:    if (at_last) state_d = ST_ERR_CHK;
            ST_ERR_CHK: state_d = rx_in_fsm ? ST_IDLE : ST_START;
            default:    state_d = ST_IDLE;
        endcase

        // A new frame (from IDLE or back-to-back from ERR_CHK) recaptures config.
        if ((state_d == ST_START) && ((state_q == ST_IDLE) || (state_q == ST_ERR_CHK))) begin
            prescale_d = legal_prescale(prescale_fsm);
            par_en_d   = par_en_fsm;
        end

        // Back-to-back frame: the ERR_CHK cycle stands in for edge 0 of START.
        cnt_clear   = (state_q == ST_IDLE) || (state_d == ST_IDLE);
        cnt_preload = (state_q == ST_ERR_CHK) && (state_d == ST_START);
        cnt_en      = (state_q != ST_IDLE);
    end

    // Outputs decoded from registered state and counters.
    always_comb begin
        dat_samp_en_fsm = 1'b0;
        strt_chk_en_fsm = 1'b0;
        deser_en_fsm    = 1'b0;
        par_chk_en_fsm  = 1'b0;
        stop_chk_en_fsm = 1'b0;
        data_valid_fsm  = 1'b0;
        busy_fsm        = (state_q != ST_IDLE);
        case (state_q)
            ST_START: begin
                dat_samp_en_fsm = 1'b1;
                strt_chk_en_fsm = at_cp;
            end
            ST_DATA: begin
                dat_samp_en_fsm = 1'b1;
                deser_en_fsm    = at_cp;
            end
            ST_PARITY: begin
                dat_samp_en_fsm = 1'b1;
                par_chk_en_fsm  = at_cp;
            end
            ST_STOP: begin
                dat_samp_en_fsm = 1'b1;
                stop_chk_en_fsm = at_cp;
            end
            ST_ERR_CHK: begin
                data_valid_fsm = !stop_error_fsm && !(par_en_q && par_error_fsm);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rx_fsm.sv
// Directed bench for rx_fsm: frame timing, enables, error handling,
// back-to-back frames, asynchronous reset and configuration latching.
module tb_rx_fsm;

    logic       clk_fsm = 1'b0;
    logic       rst_fsm;
    logic       rx_in_fsm;
    logic [5:0] prescale_fsm;
    logic       par_en_fsm;
    logic       strt_glitch_fsm;
    logic       par_error_fsm;
    logic       stop_error_fsm;
    logic [5:0] edge_cnt_fsm;
    logic [3:0] bit_cnt_fsm;
    logic       dat_samp_en_fsm, strt_chk_en_fsm, deser_en_fsm;
    logic       par_chk_en_fsm, stop_chk_en_fsm, data_valid_fsm, busy_fsm;

    int checks = 0;
    int failures = 0;
    int ncyc = 0;
    int dv_cnt, dv_cyc, deser_cnt, strt_cnt, par_cnt, stop_cnt, stop_edge, max_bit;
    int start_c, dv1;

    rx_fsm dut (
        .clk_fsm         (clk_fsm),
        .rst_fsm         (rst_fsm),
        .rx_in_fsm       (rx_in_fsm),
        .prescale_fsm    (prescale_fsm),
        .par_en_fsm      (par_en_fsm),
        .strt_glitch_fsm (strt_glitch_fsm),
        .par_error_fsm   (par_error_fsm),
        .stop_error_fsm  (stop_error_fsm),
        .edge_cnt_fsm    (edge_cnt_fsm),
        .bit_cnt_fsm     (bit_cnt_fsm),
        .dat_samp_en_fsm (dat_samp_en_fsm),
        .strt_chk_en_fsm (strt_chk_en_fsm),
        .deser_en_fsm    (deser_en_fsm),
        .par_chk_en_fsm  (par_chk_en_fsm),
        .stop_chk_en_fsm (stop_chk_en_fsm),
        .data_valid_fsm  (data_valid_fsm),
        .busy_fsm        (busy_fsm)
    );

    always #5 clk_fsm = ~clk_fsm;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        dv_cnt = 0; dv_cyc = 0; deser_cnt = 0; strt_cnt = 0;
        par_cnt = 0; stop_cnt = 0; stop_edge = -1; max_bit = 0;
    endtask

    // Advance n clocks, sampling outputs on each falling edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_fsm);
            ncyc++;
            if (data_valid_fsm) begin dv_cnt++; dv_cyc = ncyc; end
            if (deser_en_fsm) deser_cnt++;
            if (strt_chk_en_fsm) strt_cnt++;
            if (par_chk_en_fsm) par_cnt++;
            if (stop_chk_en_fsm) begin stop_cnt++; stop_edge = int'(edge_cnt_fsm); end
            if (int'(bit_cnt_fsm) > max_bit) max_bit = int'(bit_cnt_fsm);
        end
    endtask

    // Drive a frame on the line; ends sampling the last edge of the stop bit.
    task automatic send_frame(input logic [7:0] d, input int p, input bit par, input int start_steps);
        rx_in_fsm = 1'b0;
        step(start_steps);
        for (int i = 0; i < 8; i++) begin
            rx_in_fsm = d[i];
            step(p);
        end
        if (par) begin
            rx_in_fsm = ^d;
            step(p);
        end
        rx_in_fsm = 1'b1;
        step(p);
    endtask

    function automatic logic [16:0] all_outs();
        return {edge_cnt_fsm, bit_cnt_fsm, dat_samp_en_fsm, strt_chk_en_fsm, deser_en_fsm,
                par_chk_en_fsm, stop_chk_en_fsm, data_valid_fsm, busy_fsm};
    endfunction

    initial begin
        rst_fsm = 1'b0; rx_in_fsm = 1'b1; prescale_fsm = 6'd8; par_en_fsm = 1'b0;
        strt_glitch_fsm = 1'b0; par_error_fsm = 1'b0; stop_error_fsm = 1'b0;
        clr_stats();

        // Reset holds everything at zero even with the line low.
        step(3);
        chk("reset_outs", 32'(all_outs()), 32'd0);
        rx_in_fsm = 1'b0;
        step(2);
        chk("reset_outs_rx_low", 32'(all_outs()), 32'd0);
        rx_in_fsm = 1'b1;
        rst_fsm = 1'b1;
        step(2);
        chk("idle_busy", 32'(busy_fsm), 32'd0);

        // P=8, no parity, 0x55.
        clr_stats();
        start_c = ncyc + 1;
        send_frame(8'h55, 8, 1'b0, 8);
        step(1);
        chk("t1_dv_cnt", 32'(dv_cnt), 32'd1);
        chk("t1_dv_time", 32'(dv_cyc - start_c), 32'd80);
        chk("t1_stop_cnt", 32'(stop_cnt), 32'd1);
        chk("t1_stop_edge", 32'(stop_edge), 32'd6);
        chk("t1_deser_cnt", 32'(deser_cnt), 32'd8);
        chk("t1_strt_cnt", 32'(strt_cnt), 32'd1);
        chk("t1_par_cnt", 32'(par_cnt), 32'd0);
        step(1);
        chk("t1_idle_busy", 32'(busy_fsm), 32'd0);

        // P=16, parity enabled, parity error reported.
        prescale_fsm = 6'd16; par_en_fsm = 1'b1; par_error_fsm = 1'b1;
        clr_stats();
        send_frame(8'hA3, 16, 1'b1, 16);
        chk("t2_max_bit", 32'(max_bit), 32'd10);
        chk("t2_par_cnt", 32'(par_cnt), 32'd1);
        chk("t2_stop_edge", 32'(stop_edge), 32'd10);
        step(1);
        chk("t2_errchk_busy", 32'(busy_fsm), 32'd1);
        chk("t2_dv_cnt", 32'(dv_cnt), 32'd0);
        step(1);
        chk("t2_busy_drop", 32'(busy_fsm), 32'd0);
        par_error_fsm = 1'b0; par_en_fsm = 1'b0;

        // P=8 false start.
        prescale_fsm = 6'd8; strt_glitch_fsm = 1'b1;
        clr_stats();
        rx_in_fsm = 1'b0;
        step(3);
        rx_in_fsm = 1'b1;
        step(5);
        chk("t3_start_edge7", 32'(edge_cnt_fsm), 32'd7);
        chk("t3_start_busy", 32'(busy_fsm), 32'd1);
        step(1);
        chk("t3_idle_busy", 32'(busy_fsm), 32'd0);
        chk("t3_idle_samp", 32'(dat_samp_en_fsm), 32'd0);
        step(4);
        chk("t3_deser_cnt", 32'(deser_cnt), 32'd0);
        chk("t3_strt_cnt", 32'(strt_cnt), 32'd1);
        chk("t3_stay_idle", 32'(busy_fsm), 32'd0);
        strt_glitch_fsm = 1'b0;

        // P=32 back-to-back frames.
        prescale_fsm = 6'd32;
        clr_stats();
        send_frame(8'h3C, 32, 1'b0, 32);
        rx_in_fsm = 1'b0;
        step(1);
        dv1 = dv_cyc;
        chk("t4_dv1", 32'(dv_cnt), 32'd1);
        step(1);
        chk("t4_b2b_edge", 32'(edge_cnt_fsm), 32'd1);
        chk("t4_b2b_bit", 32'(bit_cnt_fsm), 32'd0);
        chk("t4_b2b_busy", 32'(busy_fsm), 32'd1);
        send_frame(8'hC3, 32, 1'b0, 30);
        step(1);
        chk("t4_dv2", 32'(dv_cnt), 32'd2);
        chk("t4_dv_spacing", 32'(dv_cyc - dv1), 32'd320);
        step(1);
        chk("t4_idle_busy", 32'(busy_fsm), 32'd0);

        // Asynchronous reset in DATA bit 4, edge 3.
        prescale_fsm = 6'd8;
        clr_stats();
        rx_in_fsm = 1'b0;
        step(36);
        chk("t5_pos_bit", 32'(bit_cnt_fsm), 32'd4);
        chk("t5_pos_edge", 32'(edge_cnt_fsm), 32'd3);
        #2;
        rst_fsm = 1'b0;
        #1;
        chk("t5_async_outs", 32'(all_outs()), 32'd0);
        @(negedge clk_fsm);
        rx_in_fsm = 1'b1;
        rst_fsm = 1'b1;
        step(100);
        chk("t5_no_dv", 32'(dv_cnt), 32'd0);
        chk("t5_idle", 32'(busy_fsm), 32'd0);

        // Prescale changed 8->16 mid-frame: timing stays x8.
        clr_stats();
        prescale_fsm = 6'd8;
        rx_in_fsm = 1'b0;
        step(1);
        start_c = ncyc;
        prescale_fsm = 6'd16;
        send_frame(8'h0F, 8, 1'b0, 7);
        step(1);
        chk("t6_dv_cnt", 32'(dv_cnt), 32'd1);
        chk("t6_dv_time", 32'(dv_cyc - start_c), 32'd80);
        step(2);

        // Illegal prescale 12 behaves as 8.
        prescale_fsm = 6'd12;
        clr_stats();
        start_c = ncyc + 1;
        send_frame(8'hF0, 8, 1'b0, 8);
        step(1);
        chk("t7_dv_cnt", 32'(dv_cnt), 32'd1);
        chk("t7_dv_time", 32'(dv_cyc - start_c), 32'd80);
        chk("t7_stop_edge", 32'(stop_edge), 32'd6);
        step(1);
        chk("t7_idle_busy", 32'(busy_fsm), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
